// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter and the shared ALU.
// Bit 0 is the MSB on every multi-bit field.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [0:31] req0_a;
    logic [0:31] req0_b;
    logic [0:3]  req0_ctrl;
    logic        req1_valid;
    logic        req1_ready;
    logic [0:31] req1_a;
    logic [0:31] req1_b;
    logic [0:3]  req1_ctrl;
    logic        resp0_valid;
    logic        resp0_ready;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [0:31] resp_data;
    logic        resp_zero;
    logic        resp_of;
    logic [0:31] alu_a;
    logic [0:31] alu_b;
    logic [0:3]  alu_ctrl;
    logic [0:31] alu_out;
    logic        alu_zero;
    logic        alu_of;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output resp0_ready, resp1_ready,
        output alu_out, alu_zero, alu_of,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid,
        input  resp_data, resp_zero, resp_of,
        input  alu_a, alu_b, alu_ctrl
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  resp0_ready, resp1_ready,
        input  alu_out, alu_zero, alu_of,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid,
        output resp_data, resp_zero, resp_of,
        output alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered, held EXEC_CYCLES, then result and flags captured.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        owner;
    logic        grant;
    logic        any_valid;
    logic        accept;
    logic        resp_done;
    logic [3:0]  cnt;
    logic [0:31] alu_a;
    logic [0:31] alu_b;
    logic [0:3]  alu_ctrl;
    logic [0:31] resp_data;
    logic        resp_zero;
    logic        resp_of;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    // Under contention, hand the ALU to whoever did not win last time.
    assign grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant
                                                     : bus.req1_valid;
    assign accept = (bus.req0_valid & bus.req0_ready)
                  | (bus.req1_valid & bus.req1_ready);
    assign resp_done = owner ? (bus.resp1_valid & bus.resp1_ready)
                             : (bus.resp0_valid & bus.resp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)      state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (resp_done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.resp0_valid = 1'b0;
        bus.resp1_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req0_ready = rst_n & any_valid & ~grant;
                bus.req1_ready = rst_n & any_valid & grant;
            end
            RESP: begin
                bus.resp0_valid = ~owner;
                bus.resp1_valid = owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_of    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    alu_a      <= grant ? bus.req1_a : bus.req0_a;
                    alu_b      <= grant ? bus.req1_b : bus.req0_b;
                    alu_ctrl   <= grant ? bus.req1_ctrl : bus.req0_ctrl;
                    owner      <= grant;
                    last_grant <= grant;
                    cnt        <= 4'(EXEC_CYCLES - 1);
                end
                EXEC: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    resp_data <= bus.alu_out;
                    resp_zero <= bus.alu_zero;
                    resp_of   <= bus.alu_of;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.alu_ctrl  = alu_ctrl;
    assign bus.resp_data = resp_data;
    assign bus.resp_zero = resp_zero;
    assign bus.resp_of   = resp_of;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one DUT with EXEC_CYCLES=1, one with 4.
// Each DUT drives an adder stub; the EXEC_CYCLES=4 stub can be perturbed.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] pert4 = '0;
    logic [0:31] sum0;
    logic [0:31] sum4;
    int          n_cmp = 0;
    int          n_bad = 0;

    alu_arbiter_if bus0 ();
    alu_arbiter_if bus4 ();

    alu_arbiter #(.EXEC_CYCLES(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    alu_arbiter #(.EXEC_CYCLES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    assign sum0          = bus0.alu_a + bus0.alu_b;
    assign bus0.alu_out  = sum0;
    assign bus0.alu_zero = (sum0 == 32'd0);
    assign bus0.alu_of   = (bus0.alu_a[0] == bus0.alu_b[0]) && (sum0[0] != bus0.alu_a[0]);
    assign sum4          = bus4.alu_a + bus4.alu_b;
    assign bus4.alu_out  = sum4 ^ pert4;
    assign bus4.alu_zero = (bus4.alu_out == 32'd0);
    assign bus4.alu_of   = (bus4.alu_a[0] == bus4.alu_b[0]) && (sum4[0] != bus4.alu_a[0]);

    task automatic clear_inputs();
        bus0.req0_valid = 0; bus0.req0_a = '0; bus0.req0_b = '0; bus0.req0_ctrl = '0;
        bus0.req1_valid = 0; bus0.req1_a = '0; bus0.req1_b = '0; bus0.req1_ctrl = '0;
        bus0.resp0_ready = 0; bus0.resp1_ready = 0;
        bus4.req0_valid = 0; bus4.req0_a = '0; bus4.req0_b = '0; bus4.req0_ctrl = '0;
        bus4.req1_valid = 0; bus4.req1_a = '0; bus4.req1_b = '0; bus4.req1_ctrl = '0;
        bus4.resp0_ready = 0; bus4.resp1_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        bus0.req0_valid = 1;
        @(negedge clk); #1;
        n_cmp++;
        if ({bus0.req0_ready, bus0.req1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_ready: got %b want 00", {bus0.req0_ready, bus0.req1_ready});
        end
        n_cmp++;
        if ({bus0.resp0_valid, bus0.resp1_valid} !== 2'b00) begin
            n_bad++; $display("FAIL reset_resp_valid: got %b want 00", {bus0.resp0_valid, bus0.resp1_valid});
        end
        n_cmp++;
        if ({bus0.alu_a, bus0.alu_b, bus0.alu_ctrl} !== 68'd0) begin
            n_bad++; $display("FAIL reset_alu: got %h want 0", {bus0.alu_a, bus0.alu_b, bus0.alu_ctrl});
        end
        n_cmp++;
        if ({bus0.resp_data, bus0.resp_zero, bus0.resp_of} !== 34'd0) begin
            n_bad++; $display("FAIL reset_resp: got %h want 0", {bus0.resp_data, bus0.resp_zero, bus0.resp_of});
        end
        n_cmp++;
        if ({bus4.alu_b, bus4.resp0_valid, bus4.req0_ready} !== 34'd0) begin
            n_bad++; $display("FAIL reset_dut4: got %h want 0", {bus4.alu_b, bus4.resp0_valid, bus4.req0_ready});
        end
        bus0.req0_valid = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus0.req0_valid = 1; bus0.req0_a = 32'h7FFF_FFFF; bus0.req0_b = 32'h0000_0001;
        bus0.req0_ctrl = 4'b0000;
        #1;
        n_cmp++;
        if ({bus0.req0_ready, bus0.req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL single_ready: got %b want 10", {bus0.req0_ready, bus0.req1_ready});
        end
        @(negedge clk);
        bus0.req0_valid = 0;
        n_cmp++;
        if ({bus0.resp0_valid, bus0.alu_a} !== {1'b0, 32'h7FFF_FFFF}) begin
            n_bad++; $display("FAIL single_exec: got %h want 07fffffff", {bus0.resp0_valid, bus0.alu_a});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus0.resp0_valid, bus0.resp1_valid} !== 2'b10) begin
            n_bad++; $display("FAIL single_valid: got %b want 10", {bus0.resp0_valid, bus0.resp1_valid});
        end
        n_cmp++;
        if ({bus0.resp_data, bus0.resp_zero, bus0.resp_of} !== {32'h8000_0000, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL single_data: got %h %b %b want 80000000 0 1",
                              bus0.resp_data, bus0.resp_zero, bus0.resp_of);
        end
        bus0.resp0_ready = 1;
        @(negedge clk);
        n_cmp++;
        if ({bus0.resp0_valid, bus0.resp_data} !== {1'b0, 32'h8000_0000}) begin
            n_bad++; $display("FAIL single_done: got %h want 080000000", {bus0.resp0_valid, bus0.resp_data});
        end
        bus0.resp0_ready = 0;
    endtask

    task automatic test_zero();
        @(negedge clk);
        bus0.req1_valid = 1; bus0.req1_a = 32'hFFFF_FFFF; bus0.req1_b = 32'h0000_0001;
        bus0.req1_ctrl = 4'b1010;
        #1;
        n_cmp++;
        if ({bus0.req0_ready, bus0.req1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL zero_ready: got %b want 01", {bus0.req0_ready, bus0.req1_ready});
        end
        @(negedge clk);
        bus0.req1_valid = 0;
        bus0.resp0_ready = 1;
        n_cmp++;
        if ({bus0.alu_ctrl, bus0.alu_a} !== {4'b1010, 32'hFFFF_FFFF}) begin
            n_bad++; $display("FAIL zero_ctrl: got %h want affffffff", {bus0.alu_ctrl, bus0.alu_a});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus0.resp0_valid, bus0.resp1_valid} !== 2'b01) begin
            n_bad++; $display("FAIL zero_valid: got %b want 01", {bus0.resp0_valid, bus0.resp1_valid});
        end
        n_cmp++;
        if ({bus0.resp_data, bus0.resp_zero, bus0.resp_of} !== {32'h0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL zero_data: got %h %b %b want 00000000 1 0",
                              bus0.resp_data, bus0.resp_zero, bus0.resp_of);
        end
        @(negedge clk);
        n_cmp++;
        if (bus0.resp1_valid !== 1'b1) begin
            n_bad++; $display("FAIL zero_nonowner_ignored: got %b want 1", bus0.resp1_valid);
        end
        bus0.resp0_ready = 0;
        bus0.resp1_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (bus0.resp1_valid !== 1'b0) begin
            n_bad++; $display("FAIL zero_done: got %b want 0", bus0.resp1_valid);
        end
        bus0.resp1_ready = 0;
    endtask

    task automatic test_contention();
        logic [3:0]  exp_flags;
        logic [0:31] exp_data;
        int          slot;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        bus0.req0_valid = 1; bus0.req0_a = 32'd1; bus0.req0_b = 32'd2; bus0.req0_ctrl = 4'b0001;
        bus0.req1_valid = 1; bus0.req1_a = 32'd3; bus0.req1_b = 32'd4; bus0.req1_ctrl = 4'b0010;
        bus0.resp0_ready = 1; bus0.resp1_ready = 1;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            slot = (c / 3) % 2;
            exp_flags = 4'b0000;
            if (c % 3 == 0) exp_flags = (slot == 0) ? 4'b1000 : 4'b0100;
            if (c % 3 == 2) exp_flags = (slot == 0) ? 4'b0010 : 4'b0001;
            n_cmp++;
            if ({bus0.req0_ready, bus0.req1_ready, bus0.resp0_valid, bus0.resp1_valid} !== exp_flags) begin
                n_bad++; $display("FAIL contention_c%0d: got %b want %b", c,
                    {bus0.req0_ready, bus0.req1_ready, bus0.resp0_valid, bus0.resp1_valid}, exp_flags);
            end
            if (c % 3 == 2) begin
                exp_data = (slot == 0) ? 32'd3 : 32'd7;
                n_cmp++;
                if (bus0.resp_data !== exp_data) begin
                    n_bad++; $display("FAIL contention_data_c%0d: got %h want %h", c, bus0.resp_data, exp_data);
                end
            end
        end
        @(negedge clk);
        bus0.req0_valid = 0; bus0.req1_valid = 0;
        bus0.resp0_ready = 0; bus0.resp1_ready = 0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus0.req0_valid = 1; bus0.req0_a = 32'h1234_5678; bus0.req0_b = 32'h1111_1111;
        bus0.req0_ctrl = 4'b0011;
        #1;
        n_cmp++;
        if (bus0.req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_accept: got %b want 1", bus0.req0_ready);
        end
        @(negedge clk);
        bus0.req0_valid = 0;
        bus0.req1_valid = 1; bus0.req1_a = 32'd5; bus0.req1_b = 32'd6;
        #1;
        n_cmp++;
        if (bus0.req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_exec_ready: got %b want 0", bus0.req1_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus0.resp0_valid, bus0.req1_ready, bus0.resp_data} !== {2'b10, 32'h2345_6789}) begin
                n_bad++; $display("FAIL bp_hold_%0d: got %h want 223456789", i,
                                  {bus0.resp0_valid, bus0.req1_ready, bus0.resp_data});
            end
        end
        bus0.resp0_ready = 1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus0.resp0_valid, bus0.req1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL bp_release: got %b want 01", {bus0.resp0_valid, bus0.req1_ready});
        end
        bus0.req1_valid = 0;
        bus0.resp0_ready = 0;
    endtask

    task automatic test_exec4();
        int n;
        @(negedge clk);
        bus4.req0_valid = 1; bus4.req0_a = 32'h10; bus4.req0_b = 32'h20; bus4.req0_ctrl = 4'b0110;
        #1;
        n_cmp++;
        if (bus4.req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL e4_accept: got %b want 1", bus4.req0_ready);
        end
        @(negedge clk);
        bus4.req0_valid = 0;
        bus4.req0_a = 32'h0000_DEAD;
        pert4 = 32'hFFFF_FFFF;
        n = 1;
        n_cmp++;
        if ({bus4.alu_a, bus4.alu_ctrl} !== {32'h10, 4'b0110}) begin
            n_bad++; $display("FAIL e4_alu_hold: got %h want 000000106", {bus4.alu_a, bus4.alu_ctrl});
        end
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n++;
        pert4 = '0;
        n_cmp++;
        if (bus4.resp0_valid !== 1'b0) begin
            n_bad++; $display("FAIL e4_early_valid: got %b want 0", bus4.resp0_valid);
        end
        while (bus4.resp0_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 5) begin
            n_bad++; $display("FAIL e4_latency: got %0d want 5", n);
        end
        n_cmp++;
        if ({bus4.resp_data, bus4.resp_zero, bus4.resp_of, bus4.alu_a} !== {32'h30, 2'b00, 32'h10}) begin
            n_bad++; $display("FAIL e4_data: got %h %b %b alu_a %h want 00000030 0 0 00000010",
                              bus4.resp_data, bus4.resp_zero, bus4.resp_of, bus4.alu_a);
        end
        bus4.resp0_ready = 1;
        @(negedge clk);
        bus4.req0_valid = 1;
        @(negedge clk);
        bus4.req0_valid = 0;
        n_cmp++;
        if (bus4.alu_a !== 32'h0000_DEAD) begin
            n_bad++; $display("FAIL e4_next_accept: got %h want 0000dead", bus4.alu_a);
        end
        repeat (6) @(negedge clk);
        bus4.resp0_ready = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus0.req0_valid = 1; bus0.req0_a = 32'd1; bus0.req0_b = 32'd1;
        bus0.resp0_ready = 1;
        @(negedge clk);
        bus0.req0_valid = 0;
        rst_n = 0;
        bus0.req0_valid = 1; bus0.req1_valid = 1;
        #1;
        n_cmp++;
        if ({bus0.alu_a, bus0.resp_data} !== 64'd0) begin
            n_bad++; $display("FAIL rstmid_regs: got %h want 0", {bus0.alu_a, bus0.resp_data});
        end
        n_cmp++;
        if ({bus0.req0_ready, bus0.req1_ready, bus0.resp0_valid, bus0.resp1_valid} !== 4'b0000) begin
            n_bad++; $display("FAIL rstmid_ctrl: got %b want 0000",
                {bus0.req0_ready, bus0.req1_ready, bus0.resp0_valid, bus0.resp1_valid});
        end
        @(negedge clk);
        bus0.req0_valid = 0; bus0.req1_valid = 0;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus0.resp0_valid, bus0.resp1_valid} !== 2'b00) begin
                n_bad++; $display("FAIL rstmid_no_resp_%0d: got %b want 00", i,
                                  {bus0.resp0_valid, bus0.resp1_valid});
            end
        end
        bus0.req0_valid = 1; bus0.req1_valid = 1;
        #1;
        n_cmp++;
        if ({bus0.req0_ready, bus0.req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL rstmid_first_grant: got %b want 10", {bus0.req0_ready, bus0.req1_ready});
        end
        @(negedge clk);
        bus0.req0_valid = 0; bus0.req1_valid = 0;
        repeat (3) @(negedge clk);
        bus0.resp0_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_contention();
        test_backpressure();
        test_exec4();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (operands A, B; 4-bit ctrl; outputs result, zero, overflow) between two requesters, e.g. the EX-stage integer path and the multi-cycle/branch-compare unit.
- Accepts one operation at a time through a valid/ready handshake, arbitrating round-robin between the requesters.
- Drives the ALU from registered operands, waits a configurable settle time, captures the result and flags, and holds them for the issuing requester until that requester accepts them.

Parameters:
- EXEC_CYCLES, 1: cycles the ALU inputs are held stable before capture. Legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_a  in  32 [0:31]  operand A; bit 0 is the MSB.
- req0_b  in  32 [0:31]  operand B.
- req0_ctrl  in  4 [0:3]  ALU control code, passed through unmodified.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same as requester 0.
- resp0_valid  out  1  result available for requester 0.
- resp0_ready  in  1  requester 0 accepts the result.
- resp1_valid  out  1  result available for requester 1.
- resp1_ready  in  1  requester 1 accepts the result.
- resp_data  out  32 [0:31]  captured ALU result, shared by both responses.
- resp_zero  out  1  captured zero flag.
- resp_of  out  1  captured overflow flag.
- alu_a, alu_b  out  32 [0:31]  to the ALU operand inputs.
- alu_ctrl  out  4 [0:3]  to the ALU control input.
- alu_out  in  32 [0:31]  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_of  in  1  ALU overflow flag.

Behaviour:
- Reset values (asynchronous on rst_n=0):
  - state=IDLE, last_grant=1, cnt=0.
  - alu_a, alu_b, alu_ctrl, resp_data = 0; resp_zero, resp_of = 0.
  - resp0_valid, resp1_valid, req0_ready, req1_ready = 0.
- States: IDLE, EXEC, RESP.
- IDLE, grant selection (combinational):
  - Only reqN_valid high: grant N.
  - Both valid: grant the requester other than last_grant.
  - reqN_ready = (state==IDLE) & rst_n & grant==N. At most one ready is high. Ready may depend combinationally on valid.
  - Handshake when reqN_valid & reqN_ready. On that edge:
    - alu_a/alu_b/alu_ctrl <= granted operands.
    - owner <= N, last_grant <= N, cnt <= EXEC_CYCLES-1, state <= EXEC.
  - No valid: remain in IDLE; alu_* hold their last values.
- EXEC:
  - alu_* held stable; no ready asserted.
  - cnt != 0: cnt decrements each cycle.
  - cnt == 0: on that edge capture resp_data<=alu_out, resp_zero<=alu_zero, resp_of<=alu_of; state <= RESP.
- RESP:
  - resp<owner>_valid = 1; the other resp valid = 0.
  - resp_* stable until the handshake (resp<owner>_valid & resp<owner>_ready), then state <= IDLE.
  - A resp_ready from the non-owner is ignored.
  - resp_* keep their values after the handshake until the next capture.
- Latency, request handshake at edge T to resp_valid high:
  - resp_valid is high in the cycle after edge T+EXEC_CYCLES.
  - EXEC_CYCLES=1: resp_valid is high in cycle T+2 (one EXEC cycle, then RESP).
  - Throughput: at most one operation every EXEC_CYCLES+2 cycles when responses are accepted immediately.
- Boundary conditions:
  - Requests arriving during EXEC/RESP wait with ready low. A requester must hold its valid and operands until accepted.
  - Requester 0 is granted first out of reset when both are valid.
  - Sustained contention strictly alternates 0,1,0,1.
  - resp_ready high before resp_valid has no effect.
  - resp_ready held high: the transaction completes in the first RESP cycle.
  - rst_n low mid-EXEC or mid-RESP: the transaction is dropped, all outputs go to reset values immediately, and no response is ever issued for it.
- Data: no arithmetic in this block. Operands, ctrl and flags pass through bit-exact; bit 0 is the MSB throughout.

Test Plan:
Bench ALU stub: alu_out = alu_a+alu_b mod 2^32; alu_zero = (alu_out==0); alu_of = signed add overflow.
- Single op, EXEC_CYCLES=1: req0 A=0x7FFFFFFF B=0x00000001 ctrl=0000 accepted at edge T -> resp0_valid in cycle T+2, resp_data=0x80000000, zero=0, of=1; resp1_valid stays 0.
- Zero flag: req1 A=0xFFFFFFFF B=0x00000001 -> resp1_valid, resp_data=0x00000000, zero=1, of=0; alu_ctrl matches req1_ctrl bit-exact.
- Contention: both valid continuously from reset with resp_ready=1 -> grant order 0,1,0,1. req1_ready never high while state != IDLE. Each op completes in 3 cycles.
- Back-pressure: resp0_ready held 0 for 5 cycles -> resp0_valid and resp_data stable for all 5 cycles. req1_ready stays 0 throughout. Completion occurs on the cycle resp0_ready rises.
- EXEC_CYCLES=4: operand change on alu_a is not visible until the next accept. resp_valid is high 5 cycles after the accept edge. A change on alu_out during the first 3 EXEC cycles does not affect the captured result.
- Reset mid-op: rst_n pulsed low during EXEC -> all outputs 0 immediately. After release, no resp_valid appears for the dropped op. The next simultaneous request is granted to requester 0.
